// File: rtl/iir_seq_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade:
// FSM states, tap ordering, accumulator sizing, rounding and coefficient reset values.
package iir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;
  localparam int         NTAPS  = 32'sd5;

  // Three guard bits cover the sum of five full-width products.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 32'sd3;
  endfunction

  function automatic longint round_const(input int frac);
    return 64'sd1 <<< (frac - 32'sd1);
  endfunction

  // b0 = 1.0 and every other tap 0 makes each section a passthrough.
  function automatic longint coef_reset_val(input int tap, input int frac);
    if (tap == int'(TAP_B0)) begin
      return 64'sd1 <<< frac;
    end else begin
      return 64'sd0;
    end
  endfunction

endpackage

// File: rtl/iir_sos_sequencer_if.sv
// Sample stream, filtered output and coefficient write port of the biquad sequencer.
interface iir_sos_sequencer_if #(
  parameter int NSEC = 4,
  parameter int DW   = 32,
  parameter int CW   = 18
) ();

  localparam int AW = $clog2(32'sd5 * NSEC);

  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic signed [DW-1:0] m_data;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_err;

  modport master (
    output s_valid, s_data, cfg_we, cfg_addr, cfg_data,
    input  s_ready, m_valid, m_data, cfg_err
  );

  modport slave (
    input  s_valid, s_data, cfg_we, cfg_addr, cfg_data,
    output s_ready, m_valid, m_data, cfg_err
  );

endinterface

// File: rtl/iir_mac.sv
// Shared multiply-accumulate for all biquad taps: signed product, add/subtract,
// round-half-up, saturation to DW and the sticky saturation flag.
module iir_mac
  import iir_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CW   = 18,
  parameter int FRAC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_en,
  input  logic                 acc_sub,
  input  logic                 acc_wb,
  input  logic                 sat_clr,
  input  logic signed [CW-1:0] coef,
  input  logic signed [DW-1:0] operand,
  output logic signed [DW-1:0] result,
  output logic                 sat
);

  localparam int AW = acc_width(DW, CW);
  localparam int PW = DW + CW;
  localparam logic signed [AW-1:0] RND     = AW'(round_const(FRAC));
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [AW-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic signed [PW-1:0] prod_s;
  logic signed [AW-1:0] rnd_s;
  logic signed [AW-1:0] shr_s;
  logic                 ovf_s;

  // Product is exact at DW+CW bits; the write-back cycle empties the accumulator.
  always_comb begin
    prod_s = PW'(operand) * PW'(coef);
    acc_d  = acc_q;
    if (acc_wb) begin
      acc_d = '0;
    end else if (acc_en) begin
      if (acc_sub) begin
        acc_d = acc_q - AW'(prod_s);
      end else begin
        acc_d = acc_q + AW'(prod_s);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Result is in range only when every bit above the DW-bit sign agrees with it.
  always_comb begin
    rnd_s = acc_q + RND;
    shr_s = rnd_s >>> FRAC;
    ovf_s = (shr_s[AW-1:DW-1] != '0) && (shr_s[AW-1:DW-1] != '1);
    if (!ovf_s) begin
      result = shr_s[DW-1:0];
    end else if (shr_s[AW-1]) begin
      result = SAT_MIN;
    end else begin
      result = SAT_MAX;
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (sat_clr) begin
      sat_d = 1'b0;
    end else if (acc_wb && ovf_s) begin
      sat_d = 1'b1;
    end else begin
      sat_d = sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;

endmodule

// File: rtl/iir_sos_sequencer.sv
// Cascade of NSEC Direct-Form-I biquads sharing one MAC: five tap cycles plus one
// write-back cycle per section, owning the coefficient and delay-line register files.
module iir_sos_sequencer
  import iir_seq_pkg::*;
#(
  parameter int NSEC = 4,
  parameter int DW   = 32,
  parameter int CW   = 18,
  parameter int FRAC = 16
) (
  input  logic               clk,
  input  logic               reset,
  iir_sos_sequencer_if.slave bus,
  input  logic               clear_state,
  output logic               sat,
  output logic               busy
);

  localparam int NCOEF = NTAPS * NSEC;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (NSEC > 32'sd1) ? $clog2(NSEC) : 32'sd1;
  localparam logic [SW-1:0] SEC_LAST = SW'(NSEC - 32'sd1);

  state_e               state_q, state_d;
  logic [SW-1:0]        sec_q, sec_d;
  logic [2:0]           tap_q, tap_d;
  logic signed [DW-1:0] xin_q, xin_d;
  logic signed [DW-1:0] x1_q [NSEC];
  logic signed [DW-1:0] x1_d [NSEC];
  logic signed [DW-1:0] x2_q [NSEC];
  logic signed [DW-1:0] x2_d [NSEC];
  logic signed [DW-1:0] y1_q [NSEC];
  logic signed [DW-1:0] y1_d [NSEC];
  logic signed [DW-1:0] y2_q [NSEC];
  logic signed [DW-1:0] y2_d [NSEC];
  logic signed [CW-1:0] coef_q [NCOEF];
  logic signed [CW-1:0] coef_d [NCOEF];
  logic                 m_valid_q, m_valid_d;
  logic signed [DW-1:0] m_data_q, m_data_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 idle_s, accept_s;
  logic                 mac_en_s, mac_sub_s, mac_wb_s, sat_clr_s;
  logic [AW-1:0]        coef_idx_s;
  logic signed [CW-1:0] coef_s;
  logic signed [DW-1:0] operand_s, result_s;

  assign idle_s      = (state_q == IDLE);
  assign bus.s_ready = idle_s && reset && !clear_state;
  assign accept_s    = bus.s_valid && bus.s_ready;
  assign busy        = !idle_s;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.cfg_err = cfg_err_q;

  // Section k, tap t reads coefficient 5k+t and the matching delay-line element.
  always_comb begin
    coef_idx_s = AW'(NTAPS) * AW'(sec_q) + AW'(tap_q);
    coef_s     = coef_q[coef_idx_s];
    mac_sub_s  = (tap_q == TAP_A1) || (tap_q == TAP_A2);
    case (tap_q)
      TAP_B0:  operand_s = xin_q;
      TAP_B1:  operand_s = x1_q[sec_q];
      TAP_B2:  operand_s = x2_q[sec_q];
      TAP_A1:  operand_s = y1_q[sec_q];
      TAP_A2:  operand_s = y2_q[sec_q];
      default: operand_s = '0;
    endcase
  end

  iir_mac #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .acc_en  (mac_en_s),
    .acc_sub (mac_sub_s),
    .acc_wb  (mac_wb_s),
    .sat_clr (sat_clr_s),
    .coef    (coef_s),
    .operand (operand_s),
    .result  (result_s),
    .sat     (sat)
  );

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    tap_d     = tap_q;
    xin_d     = xin_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    m_valid_d = 1'b0;
    m_data_d  = m_data_q;
    mac_en_s  = 1'b0;
    mac_wb_s  = 1'b0;
    sat_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_state) begin
          for (int i = 0; i < NSEC; i++) begin
            x1_d[i] = '0;
            x2_d[i] = '0;
            y1_d[i] = '0;
            y2_d[i] = '0;
          end
          sat_clr_s = 1'b1;
        end else if (accept_s) begin
          xin_d   = bus.s_data;
          sec_d   = '0;
          tap_d   = TAP_B0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        mac_en_s = 1'b1;
        if (tap_q == TAP_A2) begin
          tap_d   = TAP_B0;
          state_d = WB;
        end else begin
          tap_d   = tap_q + 3'd1;
        end
      end
      WB: begin
        // Only the saturated value enters the recursion and the next section.
        mac_wb_s    = 1'b1;
        x2_d[sec_q] = x1_q[sec_q];
        x1_d[sec_q] = xin_q;
        y2_d[sec_q] = y1_q[sec_q];
        y1_d[sec_q] = result_s;
        xin_d       = result_s;
        if (sec_q == SEC_LAST) begin
          m_valid_d = 1'b1;
          m_data_d  = result_s;
          state_d   = IDLE;
        end else begin
          sec_d   = sec_q + SW'(1'b1);
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write in the accepting cycle lands before the first tap, so it applies to that sample.
  always_comb begin
    coef_d    = coef_q;
    cfg_err_d = 1'b0;
    if (bus.cfg_we) begin
      if (idle_s && (bus.cfg_addr < AW'(NCOEF))) begin
        coef_d[bus.cfg_addr] = bus.cfg_data;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sec_q     <= '0;
      tap_q     <= TAP_B0;
      xin_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      for (int j = 0; j < NCOEF; j++) begin
        coef_q[j] <= CW'(coef_reset_val(j % NTAPS, FRAC));
      end
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      tap_q     <= tap_d;
      xin_q     <= xin_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      cfg_err_q <= cfg_err_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      coef_q    <= coef_d;
    end
  end

endmodule

// File: tb/tb_iir_sos_sequencer.sv
// Self-checking bench: directed cases plus random samples/coefficients against a
// behavioural cascade model using 64-bit integer arithmetic.
module tb_iir_sos_sequencer;

  localparam int NSEC  = 4;
  localparam int DW    = 32;
  localparam int CW    = 18;
  localparam int FRAC  = 16;
  localparam int NCOEF = 20;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset;
  logic clear_state;
  logic sat;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  longint mc  [NCOEF];
  longint mx1 [NSEC];
  longint mx2 [NSEC];
  longint my1 [NSEC];
  longint my2 [NSEC];
  bit     msat;

  iir_sos_sequencer_if #(.NSEC(NSEC), .DW(DW), .CW(CW)) bus ();

  iir_sos_sequencer #(.NSEC(NSEC), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear_state (clear_state),
    .sat         (sat),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint b2l(input logic b);
    return (b === 1'b1) ? 64'sd1 : 64'sd0;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NSEC; k++) begin
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
    end
    msat = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCOEF; i++) mc[i] = (i % 5 == 0) ? 64'sd65536 : 64'sd0;
    model_clear();
  endfunction

  // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, rounded half up, clipped to 32 bits.
  function automatic longint model_run(input longint xin);
    longint x = xin;
    longint acc, y;
    for (int k = 0; k < NSEC; k++) begin
      acc = mc[5*k] * x + mc[5*k+1] * mx1[k] + mc[5*k+2] * mx2[k]
          - mc[5*k+3] * my1[k] - mc[5*k+4] * my2[k];
      y = (acc + 64'sd32768) >>> FRAC;
      if (y > SMAX) begin y = SMAX; msat = 1'b1; end
      else if (y < SMIN) begin y = SMIN; msat = 1'b1; end
      mx2[k] = mx1[k]; mx1[k] = x; my2[k] = my1[k]; my1[k] = y;
      x = y;
    end
    return x;
  endfunction

  function automatic longint rand_span(input int span);
    return longint'($urandom_range(0, 2 * span)) - longint'(span);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input longint data, input bit exp_err);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'(addr);
    bus.cfg_data = 18'(data);
    tick();
    bus.cfg_we   = 1'b0;
    check_val("cfg_err", b2l(bus.cfg_err), exp_err ? 64'sd1 : 64'sd0);
    if (!exp_err) mc[addr] = data;
  endtask

  task automatic clear_pulse();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    model_clear();
    check_val("clear_sat", b2l(sat), 64'sd0);
  endtask

  task automatic accept(input longint x);
    int n = 0;
    while (bus.s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_val("s_ready", b2l(bus.s_ready), 64'sd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'(x);
    tick();
    bus.s_valid = 1'b0;
    check_val("busy_t1", b2l(busy), 64'sd1);
  endtask

  task automatic wait_out(input string tag, input longint exp, input int start);
    int cyc = start;
    while (bus.m_valid !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    check_val({tag, "_lat"}, longint'(cyc), 64'sd25);
    check_val({tag, "_data"}, 64'(bus.m_data), exp);
    check_val({tag, "_sat"}, b2l(sat), msat ? 64'sd1 : 64'sd0);
    check_val({tag, "_busy"}, b2l(busy), 64'sd0);
    tick();
    check_val({tag, "_pulse"}, b2l(bus.m_valid), 64'sd0);
    check_val({tag, "_hold"}, 64'(bus.m_data), exp);
  endtask

  task automatic send_sample(input string tag, input longint x);
    longint exp;
    accept(x);
    exp = model_run(x);
    wait_out(tag, exp, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint exp, x;
    int     nmv, nw, addr;

    reset = 1'b0; clear_state = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    model_reset();
    repeat (3) tick();
    check_val("rst_m_valid", b2l(bus.m_valid), 64'sd0);
    check_val("rst_m_data", 64'(bus.m_data), 64'sd0);
    check_val("rst_cfg_err", b2l(bus.cfg_err), 64'sd0);
    check_val("rst_sat", b2l(sat), 64'sd0);
    check_val("rst_busy", b2l(busy), 64'sd0);
    check_val("rst_s_ready", b2l(bus.s_ready), 64'sd0);
    reset = 1'b1;
    #1;
    check_val("post_rst_ready", b2l(bus.s_ready), 64'sd1);

    send_sample("pass", 64'sd256);
    check_val("pass_const", 64'(bus.m_data), 64'sd256);

    cfg_write(0, 64'sd32768, 1'b0);
    send_sample("gain_pos", 64'sd1000);
    check_val("gain_pos_const", 64'(bus.m_data), 64'sd500);
    send_sample("gain_neg", -64'sd1001);
    check_val("gain_neg_const", 64'(bus.m_data), -64'sd500);

    cfg_write(0, 64'sd65536, 1'b0);
    cfg_write(3, -64'sd32768, 1'b0);
    clear_pulse();
    for (int i = 0; i < 4; i++) begin
      send_sample("rec", (i == 0) ? 64'sd65536 : 64'sd0);
      check_val("rec_const", 64'(bus.m_data), 64'sd65536 >>> i);
    end

    cfg_write(3, 64'sd0, 1'b0);
    for (int k = 0; k < NSEC; k++) cfg_write(5 * k, 64'sd131071, 1'b0);
    clear_pulse();
    send_sample("satur", 64'sd1073741824);
    check_val("satur_const", 64'(bus.m_data), SMAX);
    check_val("satur_flag", b2l(sat), 64'sd1);
    clear_pulse();
    for (int k = 0; k < NSEC; k++) cfg_write(5 * k, 64'sd65536, 1'b0);

    cfg_write(20, 64'sd12345, 1'b1);
    tick();
    check_val("err_pulse", b2l(bus.cfg_err), 64'sd0);
    accept(64'sd300);
    exp = model_run(64'sd300);
    tick(); tick();
    cfg_write(0, 64'sd999, 1'b1);
    tick();
    check_val("busy_err_pulse", b2l(bus.cfg_err), 64'sd0);
    wait_out("busy_cfg", exp, 5);
    send_sample("after_rej", 64'sd400);
    check_val("after_rej_const", 64'(bus.m_data), 64'sd400);

    cfg_write(0, 64'sd20000, 1'b0);
    accept(64'sd5000);
    repeat (9) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    nmv = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.m_valid === 1'b1) nmv++;
      tick();
    end
    check_val("abort_no_mvalid", longint'(nmv), 64'sd0);
    check_val("abort_busy", b2l(busy), 64'sd0);
    check_val("abort_m_data", 64'(bus.m_data), 64'sd0);
    send_sample("post_abort", 64'sd256);
    check_val("post_abort_const", 64'(bus.m_data), 64'sd256);

    clear_state = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'sd777;
    #1;
    check_val("clr_s_ready", b2l(bus.s_ready), 64'sd0);
    tick();
    clear_state = 1'b0;
    bus.s_valid = 1'b0;
    model_clear();
    check_val("clr_not_taken", b2l(busy), 64'sd0);
    tick();
    check_val("clr_no_mvalid", b2l(bus.m_valid), 64'sd0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        nw = int'($urandom_range(1, 3));
        for (int w = 0; w < nw; w++) begin
          addr = int'($urandom_range(0, NCOEF - 1));
          cfg_write(addr, (addr % 5 < 3) ? rand_span(65536) : rand_span(29491), 1'b0);
        end
      end
      if ($urandom_range(0, 9) == 0) cfg_write(int'($urandom_range(20, 31)), 64'sd1, 1'b1);
      if ($urandom_range(0, 9) == 0) clear_pulse();
      if ($urandom_range(0, 7) == 0) x = longint'(int'($urandom()));
      else x = rand_span(1048576);
      send_sample("rand", x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
